// File: rtl/cond_pkg.sv
// Shared types and the ARM condition-code evaluator for the branch flag unit.
package cond_pkg;

    typedef enum logic [1:0] {
        BR_UNCOND = 2'd0,
        BR_COND   = 2'd1,
        BR_CBZ    = 2'd2,
        BR_CBNZ   = 2'd3
    } br_kind_t;

    typedef enum logic [3:0] {
        CC_EQ, CC_NE, CC_HS, CC_LO, CC_MI, CC_PL, CC_VS, CC_VC,
        CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
    } cond_t;

    localparam int NZVC_N = 3;
    localparam int NZVC_Z = 2;
    localparam int NZVC_V = 1;
    localparam int NZVC_C = 0;

    function automatic logic cond_eval(input cond_t cc, input logic [3:0] nzvc);
        logic n, z, v, c;
        n = nzvc[NZVC_N];
        z = nzvc[NZVC_Z];
        v = nzvc[NZVC_V];
        c = nzvc[NZVC_C];
        case (cc)
            CC_EQ:   cond_eval = z;
            CC_NE:   cond_eval = !z;
            CC_HS:   cond_eval = c;
            CC_LO:   cond_eval = !c;
            CC_MI:   cond_eval = n;
            CC_PL:   cond_eval = !n;
            CC_VS:   cond_eval = v;
            CC_VC:   cond_eval = !v;
            CC_HI:   cond_eval = c & !z;
            CC_LS:   cond_eval = !c | z;
            CC_GE:   cond_eval = (n == v);
            CC_LT:   cond_eval = (n != v);
            CC_GT:   cond_eval = !z & (n == v);
            CC_LE:   cond_eval = z | (n != v);
            default: cond_eval = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/rsp_fifo.sv
// 1-bit-wide synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module rsp_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] mem_q, mem_d;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is qualified by the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/cond_flag_unit.sv
// NZVC flag register, in-flight flag-op tracking and branch-condition resolution
// with a small response FIFO toward the fetch stage.
module cond_flag_unit
    import cond_pkg::*;
#(
    parameter int PEND_MAX  = 3,
    parameter int RSP_DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flag_issue,
    output logic       flag_issue_ready,
    input  logic       flag_wr_en,
    input  logic       alu_negative,
    input  logic       alu_zero,
    input  logic       alu_overflow,
    input  logic       alu_carry_out,
    input  logic       br_valid,
    output logic       br_ready,
    input  logic [1:0] br_kind,
    input  logic [3:0] br_cond,
    input  logic       br_zero,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_taken,
    output logic [3:0] flags_nzvc
);

    localparam int CNT_W = $clog2(PEND_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PEND_MAX);

    logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
    logic [3:0]       flags_q, flags_d;
    logic [3:0]       alu_nzvc, eff_nzvc;
    logic             issue_fire, wb_dec, hazard, br_fire, decision;
    logic             fifo_full, fifo_empty, fifo_head;
    br_kind_t         kind;

    assign flag_issue_ready = (pend_cnt_q != CNT_MAX);
    assign flags_nzvc       = flags_q;

    always_comb begin
        alu_nzvc   = {alu_negative, alu_zero, alu_overflow, alu_carry_out};
        eff_nzvc   = flag_wr_en ? alu_nzvc : flags_q;
        flags_d    = flag_wr_en ? alu_nzvc : flags_q;
        issue_fire = flag_issue && flag_issue_ready;
        wb_dec     = flag_wr_en && (pend_cnt_q != '0);
        pend_cnt_d = pend_cnt_q;
        if (issue_fire && !wb_dec) begin
            pend_cnt_d = pend_cnt_q + CNT_ONE;
        end else if (!issue_fire && wb_dec) begin
            pend_cnt_d = pend_cnt_q - CNT_ONE;
        end

        // A same-cycle issue is younger than the branch, so only pend_cnt_q matters;
        // with exactly one op left, its write-back this cycle is forwarded.
        kind     = br_kind_t'(br_kind);
        hazard   = (kind == BR_COND) &&
                   ((pend_cnt_q > CNT_ONE) || ((pend_cnt_q == CNT_ONE) && !flag_wr_en));
        br_ready = !fifo_full && !hazard;
        br_fire  = br_valid && br_ready;

        case (kind)
            BR_COND: decision = cond_eval(cond_t'(br_cond), eff_nzvc);
            BR_CBZ:  decision = br_zero;
            BR_CBNZ: decision = !br_zero;
            default: decision = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_cnt_q <= '0;
            flags_q    <= '0;
        end else begin
            pend_cnt_q <= pend_cnt_d;
            flags_q    <= flags_d;
        end
    end

    rsp_fifo #(
        .DEPTH(RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (br_fire),
        .push_data (decision),
        .pop       (rsp_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (fifo_head)
    );

    // Head storage is unreset, so gate it to keep rsp_taken low while empty.
    assign rsp_valid = !fifo_empty;
    assign rsp_taken = !fifo_empty && fifo_head;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit: hazard/forwarding, FIFO back-pressure, counter saturation, condition sweep.
module tb_cond_flag_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       flag_issue;
    logic       flag_issue_ready;
    logic       flag_wr_en;
    logic       alu_negative, alu_zero, alu_overflow, alu_carry_out;
    logic       br_valid;
    logic       br_ready;
    logic [1:0] br_kind;
    logic [3:0] br_cond;
    logic       br_zero;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_taken;
    logic [3:0] flags_nzvc;

    int tests;
    int fails;

    localparam logic [1:0] K_UNCOND = 2'd0;
    localparam logic [1:0] K_COND   = 2'd1;
    localparam logic [1:0] K_CBZ    = 2'd2;
    localparam logic [1:0] K_CBNZ   = 2'd3;

    cond_flag_unit #(
        .PEND_MAX(3),
        .RSP_DEPTH(2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .flag_issue       (flag_issue),
        .flag_issue_ready (flag_issue_ready),
        .flag_wr_en       (flag_wr_en),
        .alu_negative     (alu_negative),
        .alu_zero         (alu_zero),
        .alu_overflow     (alu_overflow),
        .alu_carry_out    (alu_carry_out),
        .br_valid         (br_valid),
        .br_ready         (br_ready),
        .br_kind          (br_kind),
        .br_cond          (br_cond),
        .br_zero          (br_zero),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_taken        (rsp_taken),
        .flags_nzvc       (flags_nzvc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic [3:0] nzvc);
        {alu_negative, alu_zero, alu_overflow, alu_carry_out} = nzvc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        tests++; if (flags_nzvc !== 4'b0000) begin fails++; $display("FAIL reset_flags got %b want 0000", flags_nzvc); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        tests++; if (rsp_taken !== 1'b0) begin fails++; $display("FAIL reset_rsp_taken got %b want 0", rsp_taken); end
        tests++; if (flag_issue_ready !== 1'b1) begin fails++; $display("FAIL reset_issue_ready got %b want 1", flag_issue_ready); end
        tests++; if (br_ready !== 1'b1) begin fails++; $display("FAIL reset_br_ready got %b want 1", br_ready); end
    endtask

    task automatic test_eq();
        flag_wr_en = 1'b1;
        set_alu(4'b0101);
        step();
        flag_wr_en = 1'b0;
        set_alu(4'b0000);
        tests++; if (flags_nzvc !== 4'b0101) begin fails++; $display("FAIL eq_flags got %b want 0101", flags_nzvc); end
        br_valid = 1'b1; br_kind = K_COND; br_cond = 4'd0;
        #1;
        tests++; if (br_ready !== 1'b1) begin fails++; $display("FAIL eq_br_ready got %b want 1", br_ready); end
        step();
        br_valid = 1'b0;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL eq_rsp_valid got %b want 1", rsp_valid); end
        tests++; if (rsp_taken !== 1'b1) begin fails++; $display("FAIL eq_rsp_taken got %b want 1", rsp_taken); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL eq_drained got %b want 0", rsp_valid); end
    endtask

    task automatic test_hazard();
        flag_issue = 1'b1;
        step();
        step();
        flag_issue = 1'b0;
        br_valid = 1'b1; br_kind = K_COND; br_cond = 4'd10;
        #1;
        tests++; if (br_ready !== 1'b0) begin fails++; $display("FAIL hz_pend2 got %b want 0", br_ready); end
        flag_wr_en = 1'b1;
        set_alu(4'b1000);
        #1;
        tests++; if (br_ready !== 1'b0) begin fails++; $display("FAIL hz_pend2_wb got %b want 0", br_ready); end
        step();
        flag_wr_en = 1'b0;
        #1;
        tests++; if (br_ready !== 1'b0) begin fails++; $display("FAIL hz_pend1 got %b want 0", br_ready); end
        flag_wr_en = 1'b1;
        set_alu(4'b1010);
        #1;
        tests++; if (br_ready !== 1'b1) begin fails++; $display("FAIL hz_forward_ready got %b want 1", br_ready); end
        step();
        br_valid = 1'b0; flag_wr_en = 1'b0; set_alu(4'b0000);
        tests++; if (rsp_valid !== 1'b1 || rsp_taken !== 1'b1) begin fails++; $display("FAIL hz_forward_taken got v%b t%b want v1 t1", rsp_valid, rsp_taken); end
        tests++; if (flags_nzvc !== 4'b1010) begin fails++; $display("FAIL hz_flags got %b want 1010", flags_nzvc); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        flag_issue = 1'b1;
        step();
        step();
        flag_issue = 1'b0;
        br_valid = 1'b1; br_kind = K_CBZ; br_zero = 1'b1;
        #1;
        tests++; if (br_ready !== 1'b1) begin fails++; $display("FAIL b2b_cbz_ready got %b want 1", br_ready); end
        step();
        br_kind = K_CBNZ;
        #1;
        tests++; if (br_ready !== 1'b1) begin fails++; $display("FAIL b2b_cbnz_ready got %b want 1", br_ready); end
        step();
        br_valid = 1'b0; br_zero = 1'b0;
        tests++; if (rsp_valid !== 1'b1 || rsp_taken !== 1'b1) begin fails++; $display("FAIL b2b_first got v%b t%b want v1 t1", rsp_valid, rsp_taken); end
        rsp_ready = 1'b1;
        step();
        tests++; if (rsp_valid !== 1'b1 || rsp_taken !== 1'b0) begin fails++; $display("FAIL b2b_second got v%b t%b want v1 t0", rsp_valid, rsp_taken); end
        step();
        rsp_ready = 1'b0;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty got %b want 0", rsp_valid); end
        flag_wr_en = 1'b1;
        step();
        step();
        flag_wr_en = 1'b0;
    endtask

    task automatic test_full();
        rsp_ready = 1'b0;
        br_valid = 1'b1; br_kind = K_UNCOND;
        #1;
        tests++; if (br_ready !== 1'b1) begin fails++; $display("FAIL full_first got %b want 1", br_ready); end
        step();
        tests++; if (br_ready !== 1'b1) begin fails++; $display("FAIL full_second got %b want 1", br_ready); end
        step();
        tests++; if (br_ready !== 1'b0) begin fails++; $display("FAIL full_third got %b want 0", br_ready); end
        step();
        tests++; if (rsp_valid !== 1'b1 || rsp_taken !== 1'b1) begin fails++; $display("FAIL full_hold got v%b t%b want v1 t1", rsp_valid, rsp_taken); end
        rsp_ready = 1'b1;
        #1;
        tests++; if (br_ready !== 1'b0) begin fails++; $display("FAIL full_pop_no_push got %b want 0", br_ready); end
        step();
        tests++; if (br_ready !== 1'b1) begin fails++; $display("FAIL full_third_accept got %b want 1", br_ready); end
        step();
        br_valid = 1'b0;
        tests++; if (rsp_valid !== 1'b1 || rsp_taken !== 1'b1) begin fails++; $display("FAIL full_drain got v%b t%b want v1 t1", rsp_valid, rsp_taken); end
        step();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL full_empty got %b want 0", rsp_valid); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_pend_sat();
        br_valid = 1'b0; br_kind = K_COND; br_cond = 4'd0;
        flag_issue = 1'b1;
        #1;
        tests++; if (br_ready !== 1'b1) begin fails++; $display("FAIL sat_issue_younger got %b want 1", br_ready); end
        step();
        step();
        step();
        tests++; if (flag_issue_ready !== 1'b0) begin fails++; $display("FAIL sat_at_max got %b want 0", flag_issue_ready); end
        step();
        flag_issue = 1'b0;
        flag_wr_en = 1'b1; set_alu(4'b0000);
        step();
        tests++; if (flag_issue_ready !== 1'b1) begin fails++; $display("FAIL sat_after_one_wb got %b want 1", flag_issue_ready); end
        step();
        flag_wr_en = 1'b0;
        #1;
        tests++; if (br_ready !== 1'b0) begin fails++; $display("FAIL sat_pend1 got %b want 0", br_ready); end
        flag_wr_en = 1'b1;
        step();
        flag_wr_en = 1'b0;
        #1;
        tests++; if (br_ready !== 1'b1) begin fails++; $display("FAIL sat_pend0 got %b want 1", br_ready); end
        flag_wr_en = 1'b1; set_alu(4'b1111);
        step();
        flag_wr_en = 1'b0; set_alu(4'b0000);
        tests++; if (flags_nzvc !== 4'b1111) begin fails++; $display("FAIL sat_extra_wb_flags got %b want 1111", flags_nzvc); end
        tests++; if (br_ready !== 1'b1 || flag_issue_ready !== 1'b1) begin fails++; $display("FAIL sat_no_underflow got br%b ir%b want br1 ir1", br_ready, flag_issue_ready); end
    endtask

    task automatic test_sweep();
        logic [15:0] exp_taken;
        exp_taken = 16'b1110_1010_1001_1010;
        flag_wr_en = 1'b1; set_alu(4'b1000);
        step();
        flag_wr_en = 1'b0; set_alu(4'b0000);
        for (int c = 0; c < 16; c++) begin
            br_valid = 1'b1; br_kind = K_COND; br_cond = 4'(c);
            step();
            br_valid = 1'b0;
            tests++;
            if (rsp_valid !== 1'b1 || rsp_taken !== exp_taken[c]) begin
                fails++;
                $display("FAIL sweep_cc%0d got v%b t%b want v1 t%b", c, rsp_valid, rsp_taken, exp_taken[c]);
            end
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        br_valid = 1'b1; br_kind = K_UNCOND;
        step();
        step();
        br_valid = 1'b0;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL rmid_queued got %b want 1", rsp_valid); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++; if (rsp_valid !== 1'b0 || rsp_taken !== 1'b0) begin fails++; $display("FAIL rmid_fifo got v%b t%b want v0 t0", rsp_valid, rsp_taken); end
        tests++; if (flags_nzvc !== 4'b0000) begin fails++; $display("FAIL rmid_flags got %b want 0000", flags_nzvc); end
        tests++; if (br_ready !== 1'b1) begin fails++; $display("FAIL rmid_br_ready got %b want 1", br_ready); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        flag_issue = 1'b0;
        flag_wr_en = 1'b0;
        set_alu(4'b0000);
        br_valid = 1'b0;
        br_kind = K_UNCOND;
        br_cond = 4'd0;
        br_zero = 1'b0;
        rsp_ready = 1'b0;

        test_reset();
        test_eq();
        test_hazard();
        test_back_to_back();
        test_full();
        test_pend_sat();
        test_sweep();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
